// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module  : mem_responder_pkg
// Brief   : Shared FSM state encoding and word-geometry constants for the
//           mem_responder slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int c_WORD_BITS  = 32;
    localparam int c_BYTE_BITS  = 8;
    localparam int c_WORD_BYTES = c_WORD_BITS / c_BYTE_BITS;
    localparam int c_ADDR_LSB   = 2;
    localparam int c_CNT_BITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module  : mem_array
// Brief   : Byte-enabled synchronous-write, asynchronous-read word array.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_BITS-1:0]    idx,
    input  logic [c_WORD_BITS-1:0]  wdata,
    input  logic [c_WORD_BYTES-1:0] be,
    output logic [c_WORD_BITS-1:0]  rdata
);

    // Contents are deliberately left unreset.
    logic [c_WORD_BITS-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < c_WORD_BYTES; i++) begin
                if (be[i]) begin
                    r_mem[idx][i*c_BYTE_BITS +: c_BYTE_BITS] <= wdata[i*c_BYTE_BITS +: c_BYTE_BITS];
                end
            end
        end
    end

    assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Brief   : Single-port memory slave with fixed wait states and a one-cycle
//           registered ready/err completion pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic [3:0]              be,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic                    err
);

    localparam int c_AW = $clog2(DEPTH_WORDS);
    localparam logic [c_CNT_BITS-1:0] c_CNT_LOAD =
        (WAIT_CYCLES > 0) ? c_CNT_BITS'(WAIT_CYCLES - 1) : '0;

    state_t                  r_state;
    logic [c_CNT_BITS-1:0]   r_cnt;
    logic                    r_we;
    logic                    r_err;
    logic [c_AW-1:0]         r_idx;
    logic [c_WORD_BITS-1:0]  r_wdata;
    logic [c_WORD_BYTES-1:0] r_be;

    logic                    w_req_err;
    logic                    w_mem_wr;
    logic [c_WORD_BITS-1:0]  w_mem_rdata;

    assign w_req_err = (addr[c_ADDR_LSB-1:0] != '0) ||
                       ({2'b00, addr[31:c_ADDR_LSB]} >= 32'(DEPTH_WORDS));

    // Commit happens on the edge that leaves RESP; an async reset clears
    // r_state first, so an aborted transaction never writes.
    assign w_mem_wr = (r_state == ST_RESP) && r_we && !r_err;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (c_AW)
    ) u_mem_array (
        .clk   (clk),
        .wr_en (w_mem_wr),
        .idx   (r_idx),
        .wdata (r_wdata),
        .be    (r_be),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_err   <= w_req_err;
                        r_idx   <= addr[c_AW+c_ADDR_LSB-1:c_ADDR_LSB];
                        r_wdata <= wdata;
                        r_be    <= be;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    ready   <= 1'b1;
                    err     <= r_err;
                    rdata   <= (!r_we && !r_err) ? w_mem_rdata : '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Directed scoreboard bench for mem_responder (WAIT_CYCLES 2 and 0).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int c_LAT_A = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0;
    logic [3:0]  be_a = '0;
    logic [31:0] rdata_a;
    logic        ready_a, err_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_b = '0, wdata_b = '0;
    logic [3:0]  be_b = '0;
    logic [31:0] rdata_b;
    logic        ready_b, err_b;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) u_dut_a (
        .clk   (clk),
        .rst   (rst_n),
        .req   (req_a),
        .we    (we_a),
        .addr  (addr_a),
        .wdata (wdata_a),
        .be    (be_a),
        .rdata (rdata_a),
        .ready (ready_a),
        .err   (err_a)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) u_dut_b (
        .clk   (clk),
        .rst   (rst_n),
        .req   (req_b),
        .we    (we_b),
        .addr  (addr_b),
        .wdata (wdata_b),
        .be    (be_b),
        .rdata (rdata_b),
        .ready (ready_b),
        .err   (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one transaction on DUT A; req is dropped and inputs scrambled
    // right after acceptance, which must not disturb the transaction.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; be_a = b;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_a = 1'b0; we_a = ~w; addr_a = 32'hFFFF_FFFC; wdata_a = ~d; be_a = ~b;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ready_a) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"},   32'(lat), 32'(c_LAT_A));
            check({tag, "_rdata"}, rdata_a, e.rdata);
            check({tag, "_err"},   32'(err_a), 32'(e.err));
            @(posedge clk);
            #1;
            check({tag, "_pulse"}, 32'(ready_a), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        check("rst_rdata", rdata_a,      32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        txn("wr_10",  1'b1, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0);
        txn("rd_10",  1'b0, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0);
        txn("wr_20a", 1'b1, 32'h20,   32'h11223344, 4'hF,    32'h0,        1'b0);
        txn("wr_20b", 1'b1, 32'h20,   32'hAABBCCDD, 4'b0101, 32'h0,        1'b0);
        txn("rd_20",  1'b0, 32'h20,   32'h0,        4'h0,    32'h11BB33DD, 1'b0);
        txn("rd_22",  1'b0, 32'h22,   32'h0,        4'h0,    32'h0,        1'b1);
        txn("wr_0",   1'b1, 32'h0,    32'hCAFEF00D, 4'hF,    32'h0,        1'b0);
        txn("wr_oob", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1);
        txn("rd_0",   1'b0, 32'h0,    32'h0,        4'h0,    32'hCAFEF00D, 1'b0);
        txn("wr_be0", 1'b1, 32'h10,   32'h12345678, 4'h0,    32'h0,        1'b0);
        txn("rd_10b", 1'b0, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0);
        txn("wr_8",   1'b1, 32'h8,    32'h0,        4'hF,    32'h0,        1'b0);
        txn("wr_c",   1'b1, 32'hC,    32'h0,        4'hF,    32'h0,        1'b0);

        // Reset while in WAIT aborts the write to 0x8.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'h55; be_a = 4'hF;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw_ready", 32'(ready_a), 32'd0);
        check("rstw_err",   32'(err_a),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn("rd_8", 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset while in RESP aborts the write to 0xC.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'hC; wdata_a = 32'h55; be_a = 4'hF;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn("rd_c", 1'b0, 32'hC, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset while ready is high clears the outputs immediately.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        repeat (c_LAT_A) @(posedge clk);
        #1;
        check("rstr_pre_ready", 32'(ready_a), 32'd1);
        check("rstr_pre_rdata", rdata_a, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("rstr_ready", 32'(ready_a), 32'd0);
        check("rstr_rdata", rdata_a, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait instance with req held: ready on alternate cycles only.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'h4; wdata_b = 32'h1; be_b = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b_ready_%0d", i), 32'(ready_b), 32'(i % 2));
            if (i % 2 == 1) begin
                check($sformatf("b_err_%0d", i), 32'(err_b), 32'd0);
            end
        end
        req_b = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response (0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 1: requester holds high to request an access.
REQ-006 SHALL have port we, input, 1: 1 = write (store), 0 = read (fetch/load).
REQ-007 SHALL have port addr, input, 32: byte address.
REQ-008 SHALL have port wdata, input, 32: store data.
REQ-009 SHALL have port be, input, 4: byte enables for writes; be[i] selects wdata[8i+7:8i].
REQ-010 SHALL have port rdata, output, 32: read data; valid only while ready=1 and we latched 0.
REQ-011 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: qualifies ready; 1 = access rejected.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on req=1 at a rising edge, SHALL latch addr, we, wdata, be and an error flag, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 Error flag SHALL be set if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
REQ-016 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on entry, decremented each cycle; at 0 go to RESP.
REQ-017 RESP: ready=1 for exactly one cycle, then unconditionally IDLE.
REQ-018 Latency: req sampled at edge k gives ready=1 in the cycle after edge k+WAIT_CYCLES+1.
REQ-019 Reads: rdata = word at latched addr[31:2] while in RESP; rdata=0 otherwise and on error.
REQ-020 Writes: enabled bytes commit on the edge leaving RESP; none commit on error.
REQ-021 A read in RESP of an address written by the immediately previous transaction SHALL return the new data.
REQ-022 Inputs SHALL be ignored in WAIT and RESP; req deassertion mid-transaction does not abort it.
REQ-023 req still high in IDLE after RESP SHALL start a new transaction (one-cycle bubble between transactions).
REQ-024 ready and err SHALL be driven only from registered state (no combinational path from req).
REQ-025 be=4'b0000 write SHALL complete normally with no storage change.

Reset
REQ-026 rst=0 SHALL force IDLE, counter=0, ready=0, err=0, rdata=0 immediately, independent of clk.
REQ-027 Reset during WAIT or RESP SHALL abort the transaction; no partial or full write commits.
REQ-028 Memory array contents SHALL NOT be reset.

Structure
REQ-029 State encodings (IDLE/WAIT/RESP) and word-size constants SHALL live in the shared package.
REQ-030 Storage SHALL be a sub-module mem_array (byte-enabled synchronous-write, asynchronous-read word array); FSM and counter stay in mem_responder.

Verification
REQ-031 WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read 0x10 -> ready exactly 3 cycles after each accepted req, rdata=0xDEADBEEF, err=0.
REQ-032 Byte enables: write 0x11223344 then 0xAABBCCDD with be=4'b0101 to 0x20; read -> 0x11BB33DD.
REQ-033 Errors: read addr=0x22 -> err=1, ready=1, rdata=0; write to 4*DEPTH_WORDS -> err=1 and a later read at 0x0 unchanged.
REQ-034 req held high for 10 cycles with WAIT_CYCLES=0 -> ready pulses every 2 cycles, never two consecutive cycles.
REQ-035 Reset mid-operation: write 0x55 to 0x8 (prior content 0x0), assert rst=0 in WAIT -> ready=0 at once; after release, read 0x8 returns 0x0.
REQ-036 req dropped one cycle after acceptance -> transaction still completes with ready pulse at nominal latency.
